dest_scoreboard: RTL and testbench

//  Consumer side of the ID-stage destination-register select: tracks each issued dest reg

---
 rtl/dest_sb_pkg.sv | 31 +++
 rtl/dest_sb_match.sv | 32 +++
 rtl/dest_scoreboard.sv | 133 +++++++++++++
 tb/tb_dest_scoreboard.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dest_sb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dest_sb_pkg                                                                |
// | Shared types and constants for the destination-register scoreboard.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package dest_sb_pkg;

  localparam int SB_RA_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic               valid;
    logic [SB_RA_W-1:0] dest;
    logic               is_load;
  } sb_entry_t;

  localparam sb_entry_t BUBBLE = '{valid: 1'b0, dest: {SB_RA_W{1'b0}}, is_load: 1'b0};

  // The youngest producer holds the newest value, so an EX hit outranks a MEM hit.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_EXMEM;
    else if (hit_mem) return FWD_MEMWB;
    else              return FWD_RF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dest_sb_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dest_sb_match                                                              |
// | Compares one ID source register against the EX and MEM producers.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dest_sb_match
  import dest_sb_pkg::*;
#(
  parameter int RA_W = SB_RA_W
) (
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  sb_entry_t       ex_entry,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_dest,
  output logic            hit_ex,
  output logic            hit_mem,
  output logic            hit_ex_load
);

  logic src_live;

  always_comb begin
    src_live    = use_src & (src != '0);
    hit_ex      = src_live & ex_entry.valid & (ex_entry.dest == src);
    hit_mem     = src_live & mem_valid & (mem_dest == src);
    hit_ex_load = hit_ex & ex_entry.is_load;
  end

endmodule
`default_nettype wire

// File: rtl/dest_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dest_scoreboard                                                            |
// | Tracks ID destination registers through EX/MEM/WB; generates load-use      |
// | stall, registered EX forwarding selects and the WB write port.             |
// | Optional feature macro: DEST_SB_FWD_EN (forwarding; otherwise stall-only). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module dest_scoreboard
  import dest_sb_pkg::*;
#(
  parameter int RA_W  = SB_RA_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_wreg,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_is_load,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             wb_we,
  output logic [RA_W-1:0]  wb_dest,
  output logic [CNT_W-1:0] stall_count
);

  // Load-ness only matters while the producer sits in EX; MEM/WB keep valid+dest.
  sb_entry_t        ex_q, ex_d;
  logic             mem_valid_q, mem_valid_d;
  logic [RA_W-1:0]  mem_dest_q, mem_dest_d;
  logic             wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]  wb_dest_q, wb_dest_d;
  logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic a_hit_ex, a_hit_mem, a_hit_ex_load;
  logic b_hit_ex, b_hit_mem, b_hit_ex_load;
  logic advance;

  dest_sb_match #(.RA_W(RA_W)) u_match_rs (
    .src         (id_rs),
    .use_src     (id_use_rs),
    .ex_entry    (ex_q),
    .mem_valid   (mem_valid_q),
    .mem_dest    (mem_dest_q),
    .hit_ex      (a_hit_ex),
    .hit_mem     (a_hit_mem),
    .hit_ex_load (a_hit_ex_load)
  );

  dest_sb_match #(.RA_W(RA_W)) u_match_rt (
    .src         (id_rt),
    .use_src     (id_use_rt),
    .ex_entry    (ex_q),
    .mem_valid   (mem_valid_q),
    .mem_dest    (mem_dest_q),
    .hit_ex      (b_hit_ex),
    .hit_mem     (b_hit_mem),
    .hit_ex_load (b_hit_ex_load)
  );

  always_comb begin
    stall         = 1'b0;
    advance       = 1'b0;
    ex_d          = BUBBLE;
    fwd_a_d       = FWD_RF;
    fwd_b_d       = FWD_RF;
    stall_count_d = stall_count_q;

`ifdef DEST_SB_FWD_EN
    stall = !rst & !flush & id_valid & (a_hit_ex_load | b_hit_ex_load);
`else
    // Without forwarding, any in-flight producer blocks the consumer until it reaches WB.
    stall = !rst & !flush & id_valid &
            (a_hit_ex_load | b_hit_ex_load | a_hit_ex | a_hit_mem | b_hit_ex | b_hit_mem);
`endif

    advance = id_valid & !stall & !flush;
    if (advance) begin
      ex_d = '{valid: id_wreg & (id_dest != '0), dest: id_dest, is_load: id_is_load};
`ifdef DEST_SB_FWD_EN
      fwd_a_d = fwd_sel(a_hit_ex, a_hit_mem);
      fwd_b_d = fwd_sel(b_hit_ex, b_hit_mem);
`endif
    end

    mem_valid_d = ex_q.valid;
    mem_dest_d  = ex_q.dest;
    wb_valid_d  = mem_valid_q;
    wb_dest_d   = mem_dest_q;

    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= BUBBLE;
      mem_valid_q   <= 1'b0;
      mem_dest_q    <= '0;
      wb_valid_q    <= 1'b0;
      wb_dest_q     <= '0;
      fwd_a_q       <= FWD_RF;
      fwd_b_q       <= FWD_RF;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_valid_q   <= mem_valid_d;
      mem_dest_q    <= mem_dest_d;
      wb_valid_q    <= wb_valid_d;
      wb_dest_q     <= wb_dest_d;
      fwd_a_q       <= fwd_a_d;
      fwd_b_q       <= fwd_b_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign wb_we       = wb_valid_q;
  assign wb_dest     = wb_dest_q;
  assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dest_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dest_scoreboard                                                         |
// | Table-driven directed bench for dest_scoreboard (both DEST_SB_FWD_EN builds)|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_dest_scoreboard;

  localparam int RA_W  = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_wreg, id_is_load, id_use_rs, id_use_rt, flush;
  logic [RA_W-1:0]  id_dest, id_rs, id_rt;
  logic             stall, wb_we;
  logic [1:0]       fwd_a, fwd_b;
  logic [RA_W-1:0]  wb_dest;
  logic [CNT_W-1:0] stall_count;

  always #5 clk = ~clk;

  dest_scoreboard #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_wreg     (id_wreg),
    .id_dest     (id_dest),
    .id_is_load  (id_is_load),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .flush       (flush),
    .stall       (stall),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .wb_we       (wb_we),
    .wb_dest     (wb_dest),
    .stall_count (stall_count)
  );

  typedef struct {
    logic            valid;
    logic            wreg;
    logic [RA_W-1:0] dest;
    logic            ld;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic            urs;
    logic            urt;
    logic            fl;
    logic            e_stall;
    logic [1:0]      e_fa;
    logic [1:0]      e_fb;
    logic            e_we;
    logic [RA_W-1:0] e_wd;
    int              e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic v, input logic w, input int d, input logic l,
                              input int rs, input int rt, input logic urs, input logic urt,
                              input logic fl, input logic s, input int fa, input int fb,
                              input logic we, input int wd, input int cnt);
    vec_t r;
    r.valid = v;  r.wreg = w;  r.dest = d[RA_W-1:0];  r.ld = l;
    r.rs = rs[RA_W-1:0];  r.rt = rt[RA_W-1:0];  r.urs = urs;  r.urt = urt;  r.fl = fl;
    r.e_stall = s;  r.e_fa = fa[1:0];  r.e_fb = fb[1:0];  r.e_we = we;
    r.e_wd = wd[RA_W-1:0];  r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic w, input logic [RA_W-1:0] d,
                       input logic l, input logic [RA_W-1:0] rs, input logic [RA_W-1:0] rt,
                       input logic urs, input logic urt, input logic fl);
    rst = r;  id_valid = v;  id_wreg = w;  id_dest = d;  id_is_load = l;
    id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;  flush = fl;
  endtask

  task automatic chk_regs(input string tag, input int row, input logic [1:0] fa,
                          input logic [1:0] fb, input logic we, input logic [RA_W-1:0] wd,
                          input int cnt);
    chk({tag, "_fwd_a"}, row, 32'(fwd_a), 32'(fa));
    chk({tag, "_fwd_b"}, row, 32'(fwd_b), 32'(fb));
    chk({tag, "_wb_we"}, row, 32'(wb_we), 32'(we));
    chk({tag, "_wb_dest"}, row, 32'(wb_dest), 32'(wd));
    chk({tag, "_stall_count"}, row, 32'(stall_count), cnt);
  endtask

  initial begin
    // Rows: inputs for the cycle, then outputs seen before the edge that consumes them.
    //           v  w  d  l  rs rt urs urt fl | st fa fb we wd cnt
`ifdef DEST_SB_FWD_EN
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // ALU -> $8
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));  // use $8
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 8, 0));
    tbl.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // load -> $9
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0,  1, 0, 0, 0, 0, 0));  // load-use
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 1, 9, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));  // write $0
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1));  // read $0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));  // $8 twice
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 8, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 8, 1));
    tbl.push_back(mk(1, 1,10, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));  // load -> $10
    tbl.push_back(mk(1, 0, 0, 0,10, 0, 1, 0, 1,  0, 0, 0, 0, 0, 1));  // flushed use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,10, 1));
`else
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0));  // ALU -> $8
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0));  // use $8: 2 stalls
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  0, 0, 0, 1, 8, 2));
    tbl.push_back(mk(1, 1, 9, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2));  // load -> $9
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0,  1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0,  1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 9, 0, 1, 0,  0, 0, 0, 1, 9, 4));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));  // write $0
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 4));  // read $0
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));  // $8 twice
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  1, 0, 0, 1, 8, 5));
    tbl.push_back(mk(1, 0, 0, 0, 8, 0, 1, 0, 0,  0, 0, 0, 1, 8, 6));
    tbl.push_back(mk(1, 1,10, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 6));  // load -> $10
    tbl.push_back(mk(1, 0, 0, 0,10, 0, 1, 0, 1,  0, 0, 0, 0, 0, 6));  // flushed use
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,10, 6));
`endif

    // Reset held two cycles with a live, dependent-looking instruction in ID.
    drive(1, 1, 1, 5'd8, 1, 5'd8, 5'd8, 1, 1, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", -1, 32'(stall), 32'd0);
    chk_regs("rst", -1, 2'b00, 2'b00, 1'b0, '0, 0);
    drive(0, 0, 0, '0, 0, '0, '0, 0, 0, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(0, tbl[i].valid, tbl[i].wreg, tbl[i].dest, tbl[i].ld, tbl[i].rs, tbl[i].rt,
            tbl[i].urs, tbl[i].urt, tbl[i].fl);
      #1;
      chk("stall", i, 32'(stall), 32'(tbl[i].e_stall));
      chk_regs("tbl", i, tbl[i].e_fa, tbl[i].e_fb, tbl[i].e_we, tbl[i].e_wd, tbl[i].e_cnt);
    end

    // Reset asserted while a load-use stall is active drops stall in the same cycle.
    @(negedge clk);
    drive(0, 1, 1, 5'd11, 1, '0, '0, 0, 0, 0);
    @(negedge clk);
    drive(0, 1, 0, '0, 0, '0, 5'd11, 0, 1, 0);
    #1;
    chk("ms_stall_before_rst", 0, 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("ms_stall_in_rst", 0, 32'(stall), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, '0, 0, '0, '0, 0, 0, 0);
    #1;
    chk("ms_after_rst_stall", 1, 32'(stall), 32'd0);
    chk_regs("ms_after_rst", 1, 2'b00, 2'b00, 1'b0, '0, 0);
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("ms_no_ghost_wb", k, 32'(wb_we), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
